// File: rtl/fcs_stream_engine.sv
// fcs_stream_engine: bit-serial CRC/FCS engine on a valid/ready bit stream.
// Data bits pass through with one cycle of latency. APPEND mode serialises the
// FCS onto the frame tail. CHECK mode compares the final register against the
// residue and reports the result.
module fcs_stream_engine #(
    parameter int unsigned CRC_W   = 32,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_data,
    output logic             m_last,
    output logic [CRC_W-1:0] crc_val,
    output logic             crc_done,
    output logic             crc_ok
);

    localparam int unsigned CNT_W = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);
    localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_W = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_W  = XOR_OUT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] RES_W  = RESIDUE[CRC_W-1:0];

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_APPEND} state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               m_valid_q, m_valid_d;
    logic               m_data_q, m_data_d;
    logic               m_last_q, m_last_d;
    logic [CRC_W-1:0]   crc_val_q, crc_val_d;
    logic               crc_done_q, crc_done_d;
    logic               crc_ok_q, crc_ok_d;

    logic               adv;
    logic               accept;
    logic               mode_eff;
    logic               fb;
    logic [CRC_W-1:0]   crc_next;

    assign adv      = ~m_valid_q | m_ready;
    assign s_ready  = adv & (state_q != ST_APPEND);
    assign accept   = s_valid & s_ready;
    // Mode is taken live on a frame's first bit and from the latch afterwards.
    assign mode_eff = (state_q == ST_IDLE) ? mode : mode_q;
    assign fb       = s_data ^ crc_q[CRC_W-1];
    assign crc_next = {crc_q[CRC_W-2:0], 1'b0} ^ (POLY_W & {CRC_W{fb}});

    // Next-state logic: bit absorption, FCS serialisation and output stage.
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        crc_val_d  = crc_val_q;
        crc_done_d = 1'b0;
        crc_ok_d   = crc_ok_q;

        // An advancing output stage with nothing new to carry goes empty.
        if (adv) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_CALC: begin
                if (accept) begin
                    mode_d    = mode_eff;
                    state_d   = ST_CALC;
                    crc_d     = crc_next;
                    m_valid_d = 1'b1;
                    m_data_d  = s_data;
                    m_last_d  = s_last & mode_eff;
                    if (s_last) begin
                        crc_val_d  = crc_next ^ XOR_W;
                        crc_done_d = 1'b1;
                        if (mode_eff) begin
                            crc_ok_d = (crc_next == RES_W);
                            crc_d    = INIT_W;
                            state_d  = ST_IDLE;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_APPEND;
                        end
                    end
                end
            end
            ST_APPEND: begin
                if (adv) begin
                    m_valid_d = 1'b1;
                    m_data_d  = crc_val_q[CNT_LAST - cnt_q];
                    m_last_d  = (cnt_q == CNT_LAST);
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        crc_d   = INIT_W;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            crc_q      <= INIT_W;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 1'b0;
            m_last_q   <= 1'b0;
            crc_val_q  <= '0;
            crc_done_q <= 1'b0;
            crc_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            crc_val_q  <= crc_val_d;
            crc_done_q <= crc_done_d;
            crc_ok_q   <= crc_ok_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign crc_val  = crc_val_q;
    assign crc_done = crc_done_q;
    assign crc_ok   = crc_ok_q;

endmodule

// File: tb/tb_fcs_stream_engine.sv
// Self-checking bench for fcs_stream_engine using a polynomial-division model.
module tb_fcs_stream_engine;

    localparam logic [31:0] P_POLY = 32'h04C11DB7;
    localparam logic [31:0] P_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] P_XOR  = 32'hFFFFFFFF;
    localparam logic [31:0] P_RES  = 32'hC704DD7B;

    typedef bit bitq_t[$];
    typedef struct packed {logic d; logic l;} obit_t;
    typedef struct {logic [31:0] val; logic [31:0] raw; logic chk; logic ok;} done_t;

    logic clk = 1'b0;
    logic rst_n, mode, s_valid, s_data, s_last;
    logic m_ready = 1'b1;
    logic s_ready, m_valid, m_data, m_last, crc_done, crc_ok;
    logic [31:0] crc_val;
    logic s_ready2, m_valid2, m_data2, m_last2, crc_done2, crc_ok2;
    logic [31:0] crc_val2;

    fcs_stream_engine #(.CRC_W(32), .POLY(P_POLY), .INIT(P_INIT), .XOR_OUT(P_XOR), .RESIDUE(P_RES)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .crc_val(crc_val), .crc_done(crc_done), .crc_ok(crc_ok));

    fcs_stream_engine #(.CRC_W(32), .XOR_OUT(32'h0)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .s_valid(s_valid), .s_ready(s_ready2),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid2), .m_ready(m_ready),
        .m_data(m_data2), .m_last(m_last2), .crc_val(crc_val2), .crc_done(crc_done2), .crc_ok(crc_ok2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    obit_t exp_q[$];
    done_t done_q[$];
    int last_acc = 0;
    bit rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: remainder of (INIT*x^len + M(x)*x^32) modulo G(x), by long division.
    function automatic logic [31:0] crc_raw(input bitq_t msg);
        bit a[$];
        logic [32:0] g;
        logic [31:0] r;
        g = {1'b1, P_POLY};
        foreach (msg[i]) a.push_back(msg[i]);
        for (int i = 0; i < 32; i++) a.push_back(1'b0);
        for (int j = 0; j < 32; j++) a[j] = a[j] ^ P_INIT[31-j];
        for (int i = 0; i < msg.size(); i++)
            if (a[i])
                for (int j = 0; j <= 32; j++) a[i+j] = a[i+j] ^ g[32-j];
        for (int k = 0; k < 32; k++) r[31-k] = a[msg.size() + k];
        return r;
    endfunction

    function automatic bitq_t str_bits(input string s);
        bitq_t q;
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            for (int b = 7; b >= 0; b--) q.push_back(c[b]);
        end
        return q;
    endfunction

    always @(posedge clk) begin
        #1;
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: output stream, stall stability, frame-end reports.
    logic prev_stall = 1'b0;
    logic prev_d = 1'b0;
    logic prev_l = 1'b0;
    always @(negedge clk) begin
        obit_t e;
        done_t d;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_d);
                check("hold_last", m_last, prev_l);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("extra_output_bit", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.d);
                    check("m_last", m_last, e.l);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
            if (crc_done) begin
                if (done_q.size() == 0) check("spurious_crc_done", 1, 0);
                else begin
                    d = done_q.pop_front();
                    check("crc_val", crc_val, d.val);
                    check("done_latency", cyc, last_acc + 1);
                    check("dut2_done", crc_done2, 1);
                    check("dut2_crc_val", crc_val2, d.raw);
                    if (d.chk) check("crc_ok", crc_ok, d.ok);
                end
            end
        end
    end

    task automatic send_bit(input bit d, input bit l, input bit gaps, output int acc, output bit ml);
        int t;
        bit got;
        if (gaps)
            while ($urandom_range(0, 1) == 1) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        s_valid = 1'b1; s_data = d; s_last = l;
        t = 0; got = 0; acc = 0; ml = 0;
        while (!got && t < 300) begin
            @(negedge clk);
            if (s_ready) begin got = 1; acc = cyc; ml = m_valid && m_last; end
            else t++;
        end
        if (!got) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input bitq_t msg, input bit m, input bit gaps, input bit hold, output bit first_ml);
        logic [31:0] raw, fcs;
        done_t dn;
        int acc;
        bit ml;
        raw = crc_raw(msg);
        fcs = raw ^ P_XOR;
        foreach (msg[i]) exp_q.push_back('{d: msg[i], l: m && (i == msg.size() - 1)});
        if (!m) for (int k = 0; k < 32; k++) exp_q.push_back('{d: fcs[31-k], l: (k == 31)});
        dn.val = fcs; dn.raw = raw; dn.chk = m; dn.ok = (raw == P_RES);
        done_q.push_back(dn);
        mode = m;
        first_ml = 0;
        foreach (msg[i]) begin
            send_bit(msg[i], i == msg.size() - 1, gaps, acc, ml);
            if (i == 0) begin first_ml = ml; mode = ~m; end
            if (i == msg.size() - 1) last_acc = acc;
        end
        if (!hold) begin s_valid = 1'b0; s_last = 1'b0; end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && t < 1000) begin
            @(negedge clk); t++;
        end
        if (t >= 1000) check("drain_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bitq_t msg, chk_msg, bad_msg, one;
        logic [31:0] g;
        bit ml;
        rst_n = 1'b0; mode = 1'b0; s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_crc_val", crc_val, 0);
        check("rst_crc_done", crc_done, 0);
        check("rst_crc_ok", crc_ok, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        msg = str_bits("123456789");
        check("model_fcs_123456789", crc_raw(msg) ^ P_XOR, 32'hFC891918);
        check("model_raw_123456789", crc_raw(msg), 32'h0376E6E7);
        chk_msg = msg;
        g = 32'hFC891918;
        for (int k = 31; k >= 0; k--) chk_msg.push_back(g[k]);
        check("model_residue", crc_raw(chk_msg), P_RES);

        // APPEND, always-ready downstream.
        send_frame(msg, 1'b0, 1'b0, 1'b0, ml);
        wait_idle();
        check("append_crc_val", crc_val, 32'hFC891918);
        check("append_dut2_crc_val", crc_val2, 32'h0376E6E7);

        // CHECK, good frame then corrupted frame.
        send_frame(chk_msg, 1'b1, 1'b0, 1'b0, ml);
        wait_idle();
        check("check_good_ok", crc_ok, 1);
        bad_msg = chk_msg;
        bad_msg[5] = ~bad_msg[5];
        send_frame(bad_msg, 1'b1, 1'b0, 1'b0, ml);
        wait_idle();
        check("check_bad_ok", crc_ok, 0);

        // APPEND with random backpressure and input gaps.
        rnd_ready = 1'b1;
        send_frame(msg, 1'b0, 1'b1, 1'b0, ml);
        wait_idle();
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset while the FCS tail is being emitted (cnt = 10).
        send_frame(msg, 1'b0, 1'b0, 1'b0, ml);
        repeat (10) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        check("abort_m_valid", m_valid, 0);
        check("abort_s_ready", s_ready, 1);
        check("abort_crc_val", crc_val, 0);
        @(posedge clk); #1;
        send_frame(msg, 1'b0, 1'b0, 1'b0, ml);
        wait_idle();
        check("after_abort_crc_val", crc_val, 32'hFC891918);

        // Back-to-back APPEND frames with s_valid held high.
        send_frame(msg, 1'b0, 1'b0, 1'b1, ml);
        send_frame(msg, 1'b0, 1'b0, 1'b0, ml);
        check("b2b_first_bit_after_m_last", ml, 1);
        wait_idle();
        check("b2b_crc_val", crc_val, 32'hFC891918);

        // Single-bit frame.
        one.push_back(1'b1);
        send_frame(one, 1'b0, 1'b0, 1'b0, ml);
        wait_idle();
        check("single_bit_crc_val", crc_val, crc_raw(one) ^ P_XOR);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
